led_pwm_fader: RTL and testbench



---
 rtl/led_pwm_fader.sv | 154 +++++++++++++++
 tb/tb_led_pwm_fader.sv | 350 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pwm_fader.sv
// LED PWM fader: follows the synchronized LED request level, ramps an
// N-bit duty value up or down at a fixed step rate, and drives the
// RGB pins with a PWM waveform gated by a colour mask latched while off.
//
// state     | meaning
// ----------+---------------------------------------------------------
// OFF       | duty held at 0, colour mask tracks color_sel
// RAMP_UP   | duty +1 per step pulse until it reaches full scale
// ON        | duty held at full scale, pins forced constant high
// RAMP_DOWN | duty -1 per step pulse until it reaches 0

module led_pwm_fader #(
    parameter int PWM_BITS = 8,
    parameter int STEP_DIV = 31250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       led_in,
    input  logic [2:0] color_sel,
    output logic       redled,
    output logic       greenled,
    output logic       blueled,
    output logic       busy
);

    localparam int                  PRE_W     = (STEP_DIV > 2) ? $clog2(STEP_DIV) : 1;
    localparam logic [PRE_W-1:0]    PRE_LAST  = PRE_W'(STEP_DIV - 1);
    localparam logic [PWM_BITS-1:0] DUTY_MAX  = '1;
    localparam logic [PWM_BITS-1:0] DUTY_NEAR = DUTY_MAX - 1'b1;
    localparam logic [PWM_BITS-1:0] DUTY_ONE  = PWM_BITS'(1);

    typedef enum logic [1:0] {
        OFF       = 2'd0,
        RAMP_UP   = 2'd1,
        ON        = 2'd2,
        RAMP_DOWN = 2'd3
    } state_t;

    state_t              state;
    logic [1:0]          sync_q;
    logic                led_s;
    logic [PRE_W-1:0]    presc;
    logic                step;
    logic [PWM_BITS-1:0] duty;
    logic [PWM_BITS-1:0] duty_act;
    logic [PWM_BITS-1:0] pwm_cnt;
    logic [2:0]          color_q;
    logic                p;

    assign led_s = sync_q[1];
    assign step  = (presc == PRE_LAST);
    assign p     = (state == ON) || (pwm_cnt < duty_act);

    // two-flop synchronizer for the LED request level
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], led_in};
        end
    end

    // ramp FSM: state, duty, step prescaler, colour mask and busy flag
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= OFF;
            duty    <= '0;
            presc   <= '0;
            color_q <= 3'b000;
            busy    <= 1'b0;
        end else begin
            busy  <= (state == RAMP_UP) || (state == RAMP_DOWN);
            presc <= step ? '0 : presc + 1'b1;
            case (state)
                OFF: begin
                    duty    <= '0;
                    color_q <= color_sel;
                    if (led_s) begin
                        state <= RAMP_UP;
                        presc <= '0;
                    end
                end
                RAMP_UP: begin
                    // a level change outranks a coincident step pulse
                    if (!led_s) begin
                        state <= RAMP_DOWN;
                        presc <= '0;
                    end else if (step) begin
                        if (duty >= DUTY_NEAR) begin
                            duty  <= DUTY_MAX;
                            state <= ON;
                            presc <= '0;
                        end else begin
                            duty <= duty + 1'b1;
                        end
                    end
                end
                ON: begin
                    duty <= DUTY_MAX;
                    if (!led_s) begin
                        state <= RAMP_DOWN;
                        presc <= '0;
                    end
                end
                RAMP_DOWN: begin
                    if (led_s) begin
                        state <= RAMP_UP;
                        presc <= '0;
                    end else if (step) begin
                        if (duty <= DUTY_ONE) begin
                            duty  <= '0;
                            state <= OFF;
                            presc <= '0;
                        end else begin
                            duty <= duty - 1'b1;
                        end
                    end
                end
                default: begin
                    state <= OFF;
                    duty  <= '0;
                    presc <= '0;
                end
            endcase
        end
    end

    // free-running PWM counter; duty shadow reloads only at the period boundary
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt  <= '0;
            duty_act <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + 1'b1;
            if (pwm_cnt == DUTY_MAX) begin
                duty_act <= duty;
            end
        end
    end

    // registered pin drivers, masked per colour
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            redled   <= 1'b0;
            greenled <= 1'b0;
            blueled  <= 1'b0;
        end else begin
            redled   <= p & color_q[2];
            greenled <= p & color_q[1];
            blueled  <= p & color_q[0];
        end
    end

endmodule

// File: tb/tb_led_pwm_fader.sv
// Bench for led_pwm_fader with a small PWM width and fast step rate so
// complete ramps fit in a few hundred cycles.

module tb_led_pwm_fader;

    localparam int PWM_BITS = 4;
    localparam int STEP_DIV = 4;
    localparam int PERIOD   = 1 << PWM_BITS;
    localparam int MAXD     = PERIOD - 1;

    localparam int M_OFF = 0;
    localparam int M_UP  = 1;
    localparam int M_ON  = 2;
    localparam int M_DN  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       led_in = 1'b0;
    logic [2:0] color_sel = 3'b010;
    logic       redled, greenled, blueled, busy;

    int vectors = 0;
    int fails   = 0;

    led_pwm_fader #(.PWM_BITS(PWM_BITS), .STEP_DIV(STEP_DIV)) dut (
        .clk       (clk),
        .rst       (rst),
        .led_in    (led_in),
        .color_sel (color_sel),
        .redled    (redled),
        .greenled  (greenled),
        .blueled   (blueled),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // ---------------- behavioural reference ----------------
    int       m_mode, m_duty, m_act, m_tick, m_cyc;
    bit       m_l1, m_l2;
    bit [2:0] m_mask;
    bit       m_red, m_green, m_blue, m_busy;
    bit       m_step, m_p;

    assign m_step = (m_mode == M_UP || m_mode == M_DN) && (((m_tick + 1) % STEP_DIV) == 0);
    assign m_p    = (m_mode == M_ON) || ((m_cyc % PERIOD) < m_act);

    function automatic int nx_mode(int md, int d, bit ls, bit st);
        case (md)
            M_OFF:   return ls ? M_UP : M_OFF;
            M_UP:    begin
                if (!ls) return M_DN;
                if (st && d + 1 >= MAXD) return M_ON;
                return M_UP;
            end
            M_ON:    return ls ? M_ON : M_DN;
            default: begin
                if (ls) return M_UP;
                if (st && d - 1 <= 0) return M_OFF;
                return M_DN;
            end
        endcase
    endfunction

    function automatic int nx_duty(int md, int d, bit ls, bit st);
        case (md)
            M_OFF:   return 0;
            M_ON:    return MAXD;
            M_UP:    return (ls && st) ? ((d + 1 > MAXD) ? MAXD : d + 1) : d;
            default: return (!ls && st) ? ((d - 1 < 0) ? 0 : d - 1) : d;
        endcase
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_mode <= M_OFF; m_duty <= 0; m_act <= 0; m_tick <= 0; m_cyc <= 0;
            m_l1 <= 1'b0; m_l2 <= 1'b0; m_mask <= 3'b000;
            m_red <= 1'b0; m_green <= 1'b0; m_blue <= 1'b0; m_busy <= 1'b0;
        end else begin
            m_red   <= m_p & m_mask[2];
            m_green <= m_p & m_mask[1];
            m_blue  <= m_p & m_mask[0];
            m_busy  <= (m_mode == M_UP) || (m_mode == M_DN);
            if ((m_cyc % PERIOD) == PERIOD - 1) m_act <= m_duty;
            m_cyc <= m_cyc + 1;
            m_l1  <= led_in;
            m_l2  <= m_l1;
            if (m_mode == M_OFF) m_mask <= color_sel;
            m_mode <= nx_mode(m_mode, m_duty, m_l2, m_step);
            m_duty <= nx_duty(m_mode, m_duty, m_l2, m_step);
            m_tick <= (nx_mode(m_mode, m_duty, m_l2, m_step) != m_mode) ? 0 : m_tick + 1;
        end
    end

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1; led_in = 1'b0; color_sel = 3'b010;
        repeat (3) @(negedge clk);
        vectors++;
        if ({redled, greenled, blueled, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_hold: pins/busy got %b want 0000", {redled, greenled, blueled, busy});
        end
        rst = 1'b0;
        for (int k = 1; k <= 1000; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== 4'b0000) begin
                fails++;
                $display("FAIL reset_idle cyc %0d: pins/busy got %b want 0000", k, {redled, greenled, blueled, busy});
            end
        end
        vectors++;
        if (dut.duty !== 4'd0) begin
            fails++;
            $display("FAIL reset_duty: got %0d want 0", dut.duty);
        end
    endtask

    task automatic test_ramp_up();
        led_in = 1'b1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL ramp_up cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
            if (k == 3 || k == 4) begin
                vectors++;
                if (busy !== (k == 4)) begin
                    fails++;
                    $display("FAIL ramp_up_busy_edge cyc %0d: got %b want %b", k, busy, (k == 4));
                end
            end
            if (k == 62 || k == 63) begin
                vectors++;
                if (dut.duty !== ((k == 63) ? 4'd15 : 4'd14)) begin
                    fails++;
                    $display("FAIL ramp_up_duty cyc %0d: got %0d want %0d", k, dut.duty, (k == 63) ? 15 : 14);
                end
            end
            if (k >= 64) begin
                vectors++;
                if ({redled, greenled, blueled, busy} !== 4'b0100) begin
                    fails++;
                    $display("FAIL on_steady cyc %0d: pins/busy got %b want 0100", k, {redled, greenled, blueled, busy});
                end
            end
        end
    endtask

    task automatic test_ramp_down();
        led_in = 1'b0;
        for (int k = 1; k <= 90; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL ramp_down cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
            if (k == 7 || k == 62 || k == 63) begin
                vectors++;
                if (dut.duty !== ((k == 7) ? 4'd14 : (k == 62) ? 4'd1 : 4'd0)) begin
                    fails++;
                    $display("FAIL ramp_down_duty cyc %0d: got %0d want %0d", k, dut.duty,
                             (k == 7) ? 14 : (k == 62) ? 1 : 0);
                end
            end
        end
        vectors++;
        if ({greenled, busy} !== 2'b00 || dut.duty !== 4'd0) begin
            fails++;
            $display("FAIL ramp_down_end: green/busy got %b duty %0d want 00 duty 0", {greenled, busy}, dut.duty);
        end
    endtask

    task automatic test_reversal();
        int guard;
        led_in = 1'b1;
        guard = 0;
        while (m_duty != 7 && guard < 200) begin
            @(posedge clk); @(negedge clk);
            guard++;
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL reversal_up cyc %0d: pins/busy got %b want %b", guard,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
        end
        vectors++;
        if (m_duty != 7) begin
            fails++;
            $display("FAIL reversal_timeout: reference duty %0d never reached 7", m_duty);
        end
        led_in = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL reversal_down cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
            if (k >= 3 && k <= 7) begin
                vectors++;
                if (dut.duty !== ((k == 7) ? 4'd6 : 4'd7)) begin
                    fails++;
                    $display("FAIL reversal_duty cyc %0d: got %0d want %0d", k, dut.duty, (k == 7) ? 6 : 7);
                end
            end
        end
        vectors++;
        if (dut.duty !== 4'd0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL reversal_floor: duty %0d busy %b want duty 0 busy 0", dut.duty, busy);
        end
    endtask

    task automatic test_color_freeze();
        int guard;
        int red_hi, green_hi;
        led_in = 1'b1;
        guard = 0;
        while (m_mode != M_ON && guard < 120) begin
            if (guard == 20) color_sel = 3'b101;
            @(posedge clk); @(negedge clk);
            guard++;
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL color_ramp cyc %0d: pins/busy got %b want %b", guard,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
        end
        repeat (3) begin @(posedge clk); @(negedge clk); end
        vectors++;
        if ({redled, greenled, blueled} !== 3'b010) begin
            fails++;
            $display("FAIL color_frozen: pins got %b want 010", {redled, greenled, blueled});
        end
        led_in = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL color_down cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
        end
        led_in = 1'b1;
        red_hi = 0; green_hi = 0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            red_hi += int'(redled);
            green_hi += int'(greenled);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL color_reramp cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
        end
        vectors++;
        if (red_hi == 0 || green_hi != 0) begin
            fails++;
            $display("FAIL color_new_mask: red high %0d green high %0d want red>0 green 0", red_hi, green_hi);
        end
        led_in = 1'b0;
        color_sel = 3'b010;
        repeat (100) begin @(posedge clk); @(negedge clk); end
    endtask

    task automatic test_reset_mid_ramp();
        int guard;
        led_in = 1'b1;
        guard = 0;
        while (m_duty != 9 && guard < 200) begin
            @(posedge clk); @(negedge clk);
            guard++;
        end
        vectors++;
        if (m_duty != 9 || dut.duty !== 4'd9) begin
            fails++;
            $display("FAIL rst_mid_setup: duty got %0d want 9", dut.duty);
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({redled, greenled, blueled, busy} !== 4'b0000) begin
            fails++;
            $display("FAIL rst_mid_async: pins/busy got %b want 0000", {redled, greenled, blueled, busy});
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL rst_mid_restart cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
            if (k == 6 || k == 7) begin
                vectors++;
                if (dut.duty !== ((k == 7) ? 4'd1 : 4'd0)) begin
                    fails++;
                    $display("FAIL rst_mid_first_step cyc %0d: got %0d want %0d", k, dut.duty, (k == 7) ? 1 : 0);
                end
            end
        end
    endtask

    task automatic test_random();
        int hold;
        hold = 0;
        for (int k = 1; k <= 3000; k++) begin
            if (hold == 0) begin
                led_in = 1'($urandom_range(1, 0));
                hold = $urandom_range(80, 1);
            end
            hold--;
            if ($urandom_range(9, 0) == 0) color_sel = 3'($urandom);
            @(posedge clk); @(negedge clk);
            vectors++;
            if ({redled, greenled, blueled, busy} !== {m_red, m_green, m_blue, m_busy}) begin
                fails++;
                $display("FAIL random cyc %0d: pins/busy got %b want %b", k,
                         {redled, greenled, blueled, busy}, {m_red, m_green, m_blue, m_busy});
            end
        end
    endtask

    initial begin
        test_reset();
        test_ramp_up();
        test_ramp_down();
        test_reversal();
        test_color_freeze();
        test_reset_mid_ramp();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
